rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter with grant hold and hold timeout.
- Sits directly upstream of the 4-to-2 encoder stage. Its registered one-hot grant bus drives the encoder's four inputs (gnt[0]..gnt[3] map to a,b,c,d).
- Also provides its own registered 2-bit index and a valid flag, so consumers need not re-encode.
- Guarantees at most one grant bit is high in any cycle, so the downstream encoder only ever sees legal one-hot or all-zero inputs.

---
 rtl/rr_arbiter4.sv | 104 ++++++++++
 tb/tb_rr_arbiter4.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and hold timeout.
// Registered one-hot grant, binary index and valid; one bubble cycle between grants.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD out of range");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
    $error("rr_arbiter4: CNT_W too narrow for MAX_HOLD");
  end

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [3:0]       gnt_q;
  logic [1:0]       idx_q;
  logic             valid_q;
  logic             timeout_q;

  logic [1:0] pick_idx;
  logic       pick_found;
  logic [1:0] cand;
  logic       release_c;
  logic       expire_c;

  // Rotating priority search: walk downwards so the lowest offset from ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    release_c = done | ~req[idx_q];
    expire_c  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      idx_q      <= 2'd0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (pick_found) begin
            gnt_q      <= 4'b0001 << pick_idx;
            idx_q      <= pick_idx;
            valid_q    <= 1'b1;
            ptr_q      <= pick_idx + 2'd1;
            hold_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (release_c || expire_c) begin
            // Release takes precedence, so a coincident done suppresses the timeout pulse.
            gnt_q      <= 4'b0000;
            idx_q      <= 2'd0;
            valid_q    <= 1'b0;
            timeout_q  <= ~release_c;
            hold_cnt_q <= '0;
            state_q    <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: cycle model of the grant rules checked every negedge,
// plus directed scenarios with hand-computed expectations.
module tb_rr_arbiter4;

  localparam int unsigned MaxHold = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter4 #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Model: holder index (-1 = none), next-priority pointer, cycles held so far.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_age    = 0;
  bit m_to     = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_holder <= -1;
      m_ptr    <= 0;
      m_age    <= 0;
      m_to     <= 1'b0;
    end else if (m_holder < 0) begin
      m_to <= 1'b0;
      if (first_from(req, m_ptr) >= 0) begin
        m_holder <= first_from(req, m_ptr);
        m_ptr    <= (first_from(req, m_ptr) + 1) % 4;
        m_age    <= 1;
      end
    end else if (done || !req[m_holder]) begin
      m_holder <= -1;
      m_to     <= 1'b0;
    end else if (m_age == int'(MaxHold)) begin
      m_holder <= -1;
      m_to     <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    eg = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
    check("model_gnt", 8'(gnt), 8'(eg));
    check("model_idx", 8'(gnt_idx), (m_holder < 0) ? 8'd0 : 8'(m_holder));
    check("model_valid", 8'(gnt_valid), 8'(m_holder >= 0));
    check("model_timeout", 8'(timeout), 8'(m_to));
    check("inv_onehot", 8'($countones(gnt) <= 1), 8'd1);
    check("inv_to_vs_valid", 8'(timeout & gnt_valid), 8'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (gnt_valid) ok = 1'b1;
    end
    if (!ok) fail_now(name);
  endtask

  // Called at a negedge with a grant showing; returns at the first negedge without one.
  task automatic grant_len(output int len, output logic [1:0] idx);
    len = 0;
    idx = gnt_idx;
    while (gnt_valid && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int         len;
    logic [1:0] idx;
    logic [3:0] prev;
    int         seq[$];
    int         exp_seq[5];

    #1 rst = 1'b1;

    // Single requester, one-cycle latency.
    do_reset();
    check("rst_gnt", 8'(gnt), 8'h0);
    check("rst_timeout", 8'(timeout), 8'h0);
    req = 4'b0100;
    @(negedge clk);
    check("single_gnt", 8'(gnt), 8'h4);
    check("single_idx", 8'(gnt_idx), 8'd2);
    check("single_valid", 8'(gnt_valid), 8'd1);
    req = 4'b0000;
    @(negedge clk);
    check("single_drop", 8'(gnt), 8'h0);

    // Round robin with done on the second cycle of each grant.
    do_reset();
    req  = 4'b1111;
    prev = 4'b0000;
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      @(negedge clk);
      if (gnt_valid && prev == 4'b0000) seq.push_back(int'(gnt_idx));
      done = gnt_valid && (gnt == prev);
      prev = gnt;
    end
    done    = 1'b0;
    req     = 4'b0000;
    exp_seq = '{0, 1, 2, 3, 0};
    if (seq.size() < 5) fail_now("rr_sequence_len");
    for (int i = 0; i < 5 && i < seq.size(); i++) check("rr_order", 8'(seq[i]), 8'(exp_seq[i]));

    // Single holder times out after MaxHold cycles, then re-grants immediately.
    do_reset();
    req = 4'b0001;
    wait_grant("to_wait", 5);
    grant_len(len, idx);
    check("to_len", 8'(len), 8'd8);
    check("to_idx", 8'(idx), 8'd0);
    check("to_pulse", 8'(timeout), 8'd1);
    @(negedge clk);
    check("to_pulse_one", 8'(timeout), 8'd0);
    check("to_regrant", 8'(gnt), 8'h1);

    // Two holders alternate via timeout.
    do_reset();
    req = 4'b0011;
    wait_grant("fair_wait", 5);
    grant_len(len, idx);
    check("fair_len0", 8'(len), 8'd8);
    check("fair_idx0", 8'(idx), 8'd0);
    check("fair_to0", 8'(timeout), 8'd1);
    @(negedge clk);
    grant_len(len, idx);
    check("fair_len1", 8'(len), 8'd8);
    check("fair_idx1", 8'(idx), 8'd1);
    check("fair_to1", 8'(timeout), 8'd1);
    @(negedge clk);
    check("fair_idx2", 8'(gnt_idx), 8'd0);
    check("fair_valid2", 8'(gnt_valid), 8'd1);

    // done coincident with expiry: release wins.
    do_reset();
    req = 4'b0001;
    wait_grant("coinc_wait", 5);
    repeat (7) @(negedge clk);
    check("coinc_still_held", 8'(gnt), 8'h1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("coinc_gnt", 8'(gnt), 8'h0);
    check("coinc_timeout", 8'(timeout), 8'd0);
    @(negedge clk);
    check("coinc_regrant", 8'(gnt), 8'h1);

    // Request drop, then asynchronous reset mid-grant.
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    check("drop_gnt", 8'(gnt), 8'h2);
    req = 4'b0000;
    @(negedge clk);
    check("drop_released", 8'(gnt), 8'h0);
    req = 4'b1010;
    @(negedge clk);
    check("ptr_advanced", 8'(gnt), 8'h8);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_gnt", 8'(gnt), 8'h0);
    check("async_rst_valid", 8'(gnt_valid), 8'd0);
    check("async_rst_idx", 8'(gnt_idx), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", 8'(gnt), 8'h2);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
